// File: rtl/trigger_burst_gen_if.sv
// AXI-Stream bundle between the burst generator and its consumer.
//   tvalid/tlast/tdata/tstrb : driven by the master (generator)
//   tready                   : driven by the slave (averaging stage)
interface trigger_burst_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;

  modport master (input tready, output tvalid, tlast, tdata, tstrb);
  modport slave  (input tvalid, tlast, tdata, tstrb, output tready);
endinterface

// File: rtl/trigger_burst_gen.sv
// Triggered acquisition-frame source. A start pulse replays a host-loaded
// waveform AVERAGES times as AXI-Stream bursts of SAMPLES_PER_TRIGGER beats,
// with tvalid held low for GAP_CYCLES cycles between bursts so the consumer
// sees one tvalid rising edge per burst.
// Ports:
//   m00_axis_aclk / m00_axis_aresetn : clock, async active-low reset
//   start                            : sequence start (sampled in IDLE only)
//   wave_we / wave_addr / wave_wdata : waveform memory write port (IDLE only)
//   busy / done / burst_index        : sequence status
//   m00_axis                         : AXI-Stream master (tvalid/tready/tlast/tdata/tstrb)
module trigger_burst_gen #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int SAMPLES_PER_TRIGGER    = 1024,
  parameter int AVERAGES               = 128,
  parameter int GAP_CYCLES             = 16,
  parameter int ADDR_WIDTH             = $clog2(SAMPLES_PER_TRIGGER)
) (
  input  logic                              m00_axis_aclk,
  input  logic                              m00_axis_aresetn,
  input  logic                              start,
  input  logic                              wave_we,
  input  logic [ADDR_WIDTH-1:0]             wave_addr,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] wave_wdata,
  output logic                              busy,
  output logic                              done,
  output logic [15:0]                       burst_index,
  trigger_burst_gen_if.master               m00_axis
);

  localparam int                    GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(SAMPLES_PER_TRIGGER - 1);
  localparam logic [15:0]           LAST_BURST = 16'(AVERAGES - 1);
  localparam logic [GAP_W-1:0]      GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, BURST, GAP, DONE} state_t;

  logic [C_M00_AXIS_TDATA_WIDTH-1:0] mem [SAMPLES_PER_TRIGGER];

  state_t                            state_q, state_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic [15:0]                       burst_idx_q, burst_idx_d;
  logic [ADDR_WIDTH-1:0]             sample_cnt_q, sample_cnt_d;
  logic [GAP_W-1:0]                  gap_cnt_q, gap_cnt_d;
  logic                              tvalid_q, tvalid_d;
  logic                              tlast_q, tlast_d;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;

  logic                              handshake;
  logic [ADDR_WIDTH-1:0]             next_addr;
  logic [ADDR_WIDTH-1:0]             rd_addr;
  logic                              rd_en;

  assign handshake = tvalid_q & m00_axis.tready;
  // Natural wrap to 0 after the last beat of a burst.
  assign next_addr = sample_cnt_q + ADDR_WIDTH'(1);

  // Host writes land only while idle; this includes the cycle start is
  // accepted, so that write is visible to the very first beat.
  always_ff @(posedge m00_axis_aclk) begin
    if (wave_we && state_q == IDLE) begin
      mem[wave_addr] <= wave_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    burst_idx_d  = burst_idx_q;
    sample_cnt_d = sample_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tdata_d      = tdata_q;
    rd_addr      = '0;
    rd_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = FETCH;
          busy_d       = 1'b1;
          burst_idx_d  = '0;
          sample_cnt_d = '0;
          gap_cnt_d    = '0;
        end
      end

      // Two cycles: the gap counter marks the second one, on which mem[0]
      // is read into the output register together with tvalid.
      FETCH: begin
        if (gap_cnt_q != '0) begin
          rd_en    = 1'b1;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          state_d  = BURST;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      // Output register only advances on a handshake, so a stall holds
      // tvalid/tdata/tlast untouched.
      BURST: begin
        if (handshake) begin
          sample_cnt_d = next_addr;
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            if (burst_idx_q == LAST_BURST) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d   = GAP;
              gap_cnt_d = '0;
            end
          end else begin
            rd_en   = 1'b1;
            rd_addr = next_addr;
            tlast_d = (next_addr == LAST_ADDR);
          end
        end
      end

      // Final gap cycle prefetches mem[0] so tvalid rises right after it.
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          rd_en        = 1'b1;
          tvalid_d     = 1'b1;
          tlast_d      = 1'b0;
          sample_cnt_d = '0;
          burst_idx_d  = burst_idx_q + 16'd1;
          state_d      = BURST;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      DONE: begin
        done_d      = 1'b0;
        burst_idx_d = '0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (rd_en) begin
      tdata_d = mem[rd_addr];
    end
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      burst_idx_q  <= '0;
      sample_cnt_q <= '0;
      gap_cnt_q    <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      burst_idx_q  <= burst_idx_d;
      sample_cnt_q <= sample_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign burst_index     = burst_idx_q;
  assign m00_axis.tvalid = tvalid_q;
  assign m00_axis.tlast  = tlast_q;
  assign m00_axis.tdata  = tdata_q;
  assign m00_axis.tstrb  = '1;

endmodule
